// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs PACK byte-wide FIFO words into one wide word
// on a valid/ready stream, with flush-driven partial words carrying a keep mask.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH * PACK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic [PACK-1:0]       m_keep,
  output logic                  m_last,
  output logic                  busy
);

  localparam int CW = $clog2(PACK) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(PACK);
  localparam logic [CW:0]   PACK_EXT = (CW + 1)'(PACK);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [OUT_WIDTH-1:0]  acc_q, acc_d;
  logic                  m_valid_q, m_valid_d;
  logic [OUT_WIDTH-1:0]  m_data_q, m_data_d;
  logic [PACK-1:0]       m_keep_q, m_keep_d;
  logic                  m_last_q, m_last_d;

  logic                  free;
  logic                  flush_req;
  logic                  cnt_full;
  logic [CW:0]           in_flight;
  logic                  rd_ok;
  logic                  load_full;
  logic                  flush_ready;
  logic                  flush_part;
  logic                  flush_empty;
  logic [PACK-1:0]       part_keep;
  logic [OUT_WIDTH-1:0]  part_data;

  // A flush seen this cycle acts at once, so an idle packer answers in one cycle.
  always_comb begin
    free        = !m_valid_q | m_ready;
    flush_req   = flush | flush_pend_q;
    cnt_full    = (cnt_q == CNT_FULL);
    in_flight   = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};
    rd_ok       = !fifo_empty & !flush & !flush_pend_q & (in_flight < PACK_EXT);
    fifo_rd_en  = rst_n & rd_ok;
    load_full   = cnt_full & free;
    flush_ready = flush_req & !rd_pend_q;
    flush_part  = flush_ready & (cnt_q != '0) & !cnt_full & free;
    flush_empty = flush_ready & (cnt_q == '0);
  end

  always_comb begin
    part_keep = '0;
    part_data = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CW'(i) < cnt_q) begin
        part_keep[i]                          = 1'b1;
        part_data[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    rd_pend_d    = rd_ok;
    flush_pend_d = flush_pend_q;
    acc_d        = acc_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_last_d     = m_last_q;

    if (rd_pend_q) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt_q == CW'(i)) begin
          acc_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data_out;
        end
      end
      cnt_d = cnt_q + CW'(1);
    end

    if (m_valid_q & m_ready) begin
      m_valid_d = 1'b0;
    end

    if (load_full) begin
      m_valid_d = 1'b1;
      m_data_d  = acc_q;
      m_keep_d  = '1;
      m_last_d  = flush_req;
      cnt_d     = '0;
    end else if (flush_part) begin
      m_valid_d = 1'b1;
      m_data_d  = part_data;
      m_keep_d  = part_keep;
      m_last_d  = 1'b1;
      cnt_d     = '0;
    end

    if (flush) begin
      flush_pend_d = 1'b1;
    end
    if ((load_full & flush_req) | flush_part | flush_empty) begin
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      rd_pend_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      acc_q        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rd_pend_q    <= rd_pend_d;
      flush_pend_q <= flush_pend_d;
      acc_q        <= acc_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_last_q     <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;
  assign busy    = (cnt_q != '0) | rd_pend_q | flush_pend_q | m_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO feeds the packer and a byte-stream
// reference model predicts the packed words, keep masks and last markers.
module tb_fifo_rd_packer;

  localparam int DW   = 8;
  localparam int PACK = 4;
  localparam int OW   = DW * PACK;
  localparam int EW   = OW + PACK + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data_out;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic [PACK-1:0] m_keep;
  logic          m_last;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] pending[$];
  logic [EW-1:0] gotQ[$];
  logic [EW-1:0] expQ[$];
  int            gotIdx = 0;
  int            expIdx = 0;

  int            rdCount = 0;
  int            validCount = 0;
  logic          sampledValid = 1'b0;
  logic          sampledRd = 1'b0;
  logic          holdPrev = 1'b0;
  logic [EW-1:0] prevWord = '0;

  always #5 clk = ~clk;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PACK)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .flush         (flush),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_keep        (m_keep),
    .m_last        (m_last),
    .busy          (busy)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes leave the FIFO in order and are grouped PACK at a time, LSB first.
  task automatic modelPush(input logic [DW-1:0] b);
    logic [OW-1:0] d;
    pending.push_back(b);
    if (pending.size() == PACK) begin
      d = '0;
      for (int i = 0; i < PACK; i++) d[i*DW +: DW] = pending[i];
      expQ.push_back({1'b0, {PACK{1'b1}}, d});
      pending.delete();
    end
  endtask

  task automatic modelFlush();
    logic [OW-1:0]   d;
    logic [PACK-1:0] k;
    if (pending.size() != 0) begin
      d = '0;
      k = '0;
      for (int i = 0; i < pending.size(); i++) begin
        d[i*DW +: DW] = pending[i];
        k[i] = 1'b1;
      end
      expQ.push_back({1'b1, k, d});
      pending.delete();
    end
  endtask

  task automatic pushByte(input logic [DW-1:0] b);
    fifoQ.push_back(b);
    fifo_empty = 1'b0;
    modelPush(b);
  endtask

  // One clock: observe at the falling edge, then update the FIFO model after the rising edge.
  task automatic tick();
    logic rdFire;
    @(negedge clk);
    if (fifo_rd_en) begin
      rdCount++;
      checkVal("rd_while_empty", 64'(fifo_empty), 64'd0);
    end
    if (holdPrev) checkVal("hold_stable", 64'({m_last, m_keep, m_data}), 64'(prevWord));
    if (m_valid && m_ready) gotQ.push_back({m_last, m_keep, m_data});
    if (m_valid) validCount++;
    sampledValid = m_valid;
    sampledRd    = fifo_rd_en;
    holdPrev     = m_valid && !m_ready;
    prevWord     = {m_last, m_keep, m_data};
    rdFire       = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rdFire && fifoQ.size() > 0) fifo_data_out = fifoQ.pop_front();
    fifo_empty = (fifoQ.size() == 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) pushByte(first + DW'(i));
  endtask

  task automatic checkOutput(input string tag);
    int nGot;
    int nExp;
    nGot = gotQ.size() - gotIdx;
    nExp = expQ.size() - expIdx;
    checkVal({tag, "_count"}, 64'(nGot), 64'(nExp));
    for (int i = 0; i < nGot && i < nExp; i++) begin
      checkVal({tag, "_word"}, 64'(gotQ[gotIdx + i]), 64'(expQ[expIdx + i]));
    end
    gotIdx = gotQ.size();
    expIdx = expQ.size();
  endtask

  task automatic waitDrained(input string tag);
    int   budget;
    logic timedOut;
    budget   = 0;
    timedOut = 1'b0;
    while (fifoQ.size() != 0 && !timedOut) begin
      tick();
      budget++;
      if (budget > 300) timedOut = 1'b1;
    end
    checkVal({tag, "_timeout"}, 64'(timedOut), 64'd0);
    ticks(PACK + 4);
  endtask

  initial begin
    int lat;
    logic [DW-1:0] b;
    int n;

    rst_n         = 1'b0;
    flush         = 1'b0;
    m_ready       = 1'b0;
    fifo_empty    = 1'b0;
    fifo_data_out = '0;
    #12;
    checkVal("reset_rd_en",  64'(fifo_rd_en), 64'd0);
    checkVal("reset_valid",  64'(m_valid),    64'd0);
    checkVal("reset_data",   64'(m_data),     64'd0);
    checkVal("reset_keep",   64'(m_keep),     64'd0);
    checkVal("reset_last",   64'(m_last),     64'd0);
    checkVal("reset_busy",   64'(busy),       64'd0);
    fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ticks(2);

    // Basic pack with latency measured from the first read strike.
    m_ready = 1'b1;
    applyStimulus(8'h01, 8);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 0) checkVal("first_rd_en", 64'(sampledRd), 64'd1);
      if (sampledValid && lat < 0) lat = c;
    end
    checkVal("pack_latency", 64'(lat), 64'(PACK + 2));
    checkVal("basic_exp_word0", 64'(expQ[0]), {27'd0, 1'b0, 4'hF, 32'h04030201});
    checkOutput("basic");

    // Partial flush from a parked count of three.
    applyStimulus(8'hA1, 3);
    ticks(8);
    flush = 1'b1;
    tick();
    checkVal("flush_t0_valid", 64'(sampledValid), 64'd0);
    flush = 1'b0;
    modelFlush();
    tick();
    checkVal("flush_t1_valid", 64'(sampledValid), 64'd1);
    ticks(3);
    checkVal("flush_exp", 64'(expQ[expIdx]), {27'd0, 1'b1, 4'h7, 32'h00A3A2A1});
    checkOutput("partial");
    checkVal("partial_busy", 64'(busy), 64'd0);

    // Backpressure: reads stop once the held word and the accumulator are both full.
    m_ready = 1'b0;
    n = rdCount;
    applyStimulus(8'h30, 12);
    ticks(20);
    checkVal("bp_reads", 64'(rdCount - n), 64'(2 * PACK));
    checkVal("bp_valid", 64'(m_valid), 64'd1);
    checkVal("bp_no_xfer", 64'(gotQ.size() - gotIdx), 64'd0);
    m_ready = 1'b1;
    ticks(30);
    checkOutput("backpressure");

    // Flush with nothing held produces no word.
    n = validCount;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ticks(5);
    checkVal("empty_flush_valid", 64'(validCount - n), 64'd0);
    checkVal("empty_flush_busy", 64'(busy), 64'd0);

    // Two back-to-back flushes around a completing word merge into one last word.
    for (int i = 0; i < PACK; i++) begin
      b = DW'($urandom);
      fifoQ.push_back(b);
      pending.push_back(b);
    end
    fifo_empty = 1'b0;
    ticks(4);
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    modelFlush();
    ticks(6);
    checkOutput("merge");
    checkVal("merge_busy", 64'(busy), 64'd0);

    // Reset while a word is held and two more bytes sit in the accumulator.
    m_ready = 1'b0;
    applyStimulus(8'h50, 6);
    ticks(12);
    checkVal("pre_reset_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkVal("mid_reset_valid", 64'(m_valid), 64'd0);
    checkVal("mid_reset_busy",  64'(busy),    64'd0);
    expIdx   = expQ.size();
    pending.delete();
    holdPrev = 1'b0;
    tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();
    applyStimulus(8'h11, 4);
    ticks(12);
    checkVal("reset_exp", 64'(expQ[expIdx]), {27'd0, 1'b0, 4'hF, 32'h14131211});
    checkOutput("after_reset");

    // Randomized streams with random backpressure, each closed by a flush.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 14);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) ticks($urandom_range(1, 3));
        m_ready = ($urandom_range(0, 3) != 0);
        pushByte(DW'($urandom));
        tick();
      end
      while (holdPrev && $urandom_range(0, 1) == 1) tick();
      m_ready = 1'b1;
      waitDrained("rand_drain");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      modelFlush();
      ticks(4);
      checkOutput("random");
      checkVal("random_busy", 64'(busy), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
